i2c_req_scheduler: RTL and testbench

Round-robin scheduler that shares the single I2C master (address byte + data byte write engine) among `N_REQ` on-chip requesters. It latches one requester's address/data, drives the master's `go` handshake, and waits for the master's done/success status. It retries NACKed transactions up to `MAX_RETRY` times and returns a per-requester response pulse. It sits between the requester blocks and the I2C master control unit and is the only driver of the master's `go`, address and data inputs.

---
 rtl/i2c_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/i2c_req_scheduler.sv | 143 ++++++++++++++
 tb/tb_i2c_req_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C request scheduler and its round-robin picker.
package i2c_sched_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int RETRY_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = PW'((int'(ptr) + off) % N);
      if (req[cand]) begin
        onehot = N'(1) << cand;
        idx    = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_req_scheduler.sv
// Shares one I2C address+data write master among N_REQ requesters with round-robin
// arbitration, NACK retry and a per-attempt timeout.
module i2c_req_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [I2C_BYTE_W*N_REQ-1:0] req_addr,
  input  logic [I2C_BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_success,
  output logic                        resp_timeout,
  output logic                        m_go,
  output logic [I2C_BYTE_W-1:0]       m_addr,
  output logic [I2C_BYTE_W-1:0]       m_data,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic                        m_success
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [PW-1:0]      LAST_IDX  = PW'(N_REQ - 1);

  // Handshakes: a requester holds req until its one-cycle resp_valid; the master
  // accepts go by raising m_busy, and m_done/m_success count only once busy was seen.
  sched_state_e       state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TW-1:0]      tmo_cnt;

  logic [N_REQ-1:0]   arb_onehot;
  logic [PW-1:0]      arb_idx;
  logic               tmo_hit;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  // The counter value before this edge's increment; equality means TIMEOUT is reached now.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gidx         <= '0;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
      gnt          <= '0;
      resp_valid   <= '0;
      resp_success <= 1'b0;
      resp_timeout <= 1'b0;
      m_go         <= 1'b0;
      m_addr       <= '0;
      m_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req) && !m_busy) begin
            m_addr    <= req_addr[arb_idx*I2C_BYTE_W +: I2C_BYTE_W];
            m_data    <= req_data[arb_idx*I2C_BYTE_W +: I2C_BYTE_W];
            gnt       <= arb_onehot;
            gidx      <= arb_idx;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            m_go      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            m_go         <= 1'b0;
            resp_valid   <= gnt;
            resp_success <= 1'b0;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else if (m_busy) begin
            m_go  <= 1'b0;
            state <= WAIT;
          end
        end

        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A completion in the same cycle as the timeout wins over the timeout.
          if (m_done && !m_busy) begin
            if (m_success) begin
              resp_valid   <= gnt;
              resp_success <= 1'b1;
              resp_timeout <= 1'b0;
              state        <= RESP;
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              tmo_cnt   <= '0;
              m_go      <= 1'b1;
              state     <= ISSUE;
            end else begin
              resp_valid   <= gnt;
              resp_success <= 1'b0;
              resp_timeout <= 1'b0;
              state        <= RESP;
            end
          end else if (tmo_hit) begin
            resp_valid   <= gnt;
            resp_success <= 1'b0;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          resp_valid   <= '0;
          resp_success <= 1'b0;
          resp_timeout <= 1'b0;
          gnt          <= '0;
          ptr          <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_scheduler.sv
// Directed bench for i2c_req_scheduler with a small behavioral I2C master model.
module tb_i2c_req_scheduler;

  localparam int N   = 4;
  localparam int MR  = 2;
  localparam int TMO = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  gnt, resp_valid;
  logic          resp_success, resp_timeout, m_go;
  logic [7:0]    m_addr, m_data;
  logic          m_busy, m_done, m_success;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Master model controls, written only by the test tasks.
  int nack_limit = 0;
  int epoch      = 0;
  bit hang       = 1'b0;
  int start_dly  = 0;

  // Master model state, written only by the model.
  int phase = 0, cnt = 0, dcnt = 0, nacks = 0, my_epoch = 0;

  // Monitor state, written only by the monitor.
  int go_cnt = 0, last_go_cyc = 0, resp_cyc = 0, gnt_bad = 0;
  bit go_prev = 1'b0;

  i2c_req_scheduler #(
    .N_REQ     (N),
    .MAX_RETRY (MR),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_success (resp_success),
    .resp_timeout (resp_timeout),
    .m_go         (m_go),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_success    (m_success)
  );

  // Clock and cycle counter
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // Master model: accepts go when idle, stays busy LAT cycles, holds done until next go.
  initial begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_success = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_success = 1'b0; phase = 0;
      end else begin
        case (phase)
          0: if (m_go) begin
               if (my_epoch != epoch) begin my_epoch = epoch; nacks = 0; end
               if (start_dly == 0) begin
                 m_busy = 1'b1; m_done = 1'b0; cnt = LAT; phase = 2;
               end else begin
                 dcnt = start_dly; phase = 1;
               end
             end
          1: begin
               dcnt--;
               if (dcnt == 0) begin m_busy = 1'b1; m_done = 1'b0; cnt = LAT; phase = 2; end
             end
          default: if (!hang) begin
               cnt--;
               if (cnt == 0) begin
                 m_busy = 1'b0; m_done = 1'b1;
                 m_success = (nacks >= nack_limit);
                 if (!m_success) nacks++;
                 phase = 0;
               end
             end
        endcase
      end
    end
  end

  // Monitor: counts go rising edges, stamps go/response cycles, flags non-one-hot grants.
  initial forever begin
    @(negedge clk);
    if (m_go && !go_prev) begin go_cnt++; last_go_cyc = cyc; end
    go_prev = m_go;
    if (resp_valid != '0) resp_cyc = cyc;
    if ($countones(gnt) > 1) gnt_bad++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_resp(output bit seen, input int limit);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (resp_valid != '0) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    n_checks++; if (resp_success !== 1'b0) begin n_fail++; $display("FAIL reset_resp_success: got %b expected 0", resp_success); end
    n_checks++; if (resp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_resp_timeout: got %b expected 0", resp_timeout); end
    n_checks++; if (m_go !== 1'b0) begin n_fail++; $display("FAIL reset_m_go: got %b expected 0", m_go); end
    n_checks++; if (m_addr !== 8'h00) begin n_fail++; $display("FAIL reset_m_addr: got %h expected 00", m_addr); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit seen;
    int g0;
    req_addr = {8'h44, 8'hA0, 8'h22, 8'h33};
    req_data = {8'h66, 8'h5C, 8'h77, 8'h88};
    g0 = go_cnt;
    req = 4'b0100;
    step();
    n_checks++; if (m_go !== 1'b1) begin n_fail++; $display("FAIL single_go_latency: got %b expected 1", m_go); end
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    n_checks++; if (m_addr !== 8'hA0) begin n_fail++; $display("FAIL single_m_addr: got %h expected a0", m_addr); end
    n_checks++; if (m_data !== 8'h5C) begin n_fail++; $display("FAIL single_m_data: got %h expected 5c", m_data); end
    req_addr = '1;
    req_data = '0;
    wait_resp(seen, 50);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL single_resp_seen: got none expected a response within 50 cycles"); end
    n_checks++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 0100", resp_valid); end
    n_checks++; if (resp_success !== 1'b1) begin n_fail++; $display("FAIL single_success: got %b expected 1", resp_success); end
    n_checks++; if (resp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b expected 0", resp_timeout); end
    n_checks++; if (go_cnt - g0 != 1) begin n_fail++; $display("FAIL single_go_count: got %0d expected 1", go_cnt - g0); end
    n_checks++; if (m_addr !== 8'hA0) begin n_fail++; $display("FAIL single_payload_held: got %h expected a0", m_addr); end
    req = '0;
    step();
    n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_resp_pulse: got %b expected 0000", resp_valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_clear: got %b expected 0000", gnt); end
    req_addr = {8'h48, 8'h46, 8'h44, 8'h42};
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
  endtask

  task automatic test_fairness();
    bit seen;
    int bad0, gap;
    logic [N-1:0] exp_g;
    do_reset();
    bad0 = gnt_bad;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_g = 4'b0001 << (t % 4);
      wait_resp(seen, 50);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL fair_resp_seen[%0d]: got none expected a response", t); end
      n_checks++; if (resp_valid !== exp_g) begin n_fail++; $display("FAIL fair_order[%0d]: got %b expected %b", t, resp_valid, exp_g); end
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt_in_resp[%0d]: got %b expected %b", t, gnt, exp_g); end
      if (t == 0) begin
        gap = 0;
        while (gap < 6) begin
          step();
          gap++;
          if (gnt != '0) break;
        end
        n_checks++; if (gap != 2) begin n_fail++; $display("FAIL fair_resp_to_grant: got %0d cycles expected 2", gap); end
      end
    end
    n_checks++; if (gnt_bad - bad0 != 0) begin n_fail++; $display("FAIL fair_onehot: got %0d bad cycles expected 0", gnt_bad - bad0); end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_nack();
    bit seen;
    int g0;
    nack_limit = 99;
    epoch++;
    g0 = go_cnt;
    req = 4'b0001;
    wait_resp(seen, 200);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL nack_resp_seen: got none expected a response"); end
    n_checks++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL nack_resp_valid: got %b expected 0001", resp_valid); end
    n_checks++; if (resp_success !== 1'b0) begin n_fail++; $display("FAIL nack_success: got %b expected 0", resp_success); end
    n_checks++; if (resp_timeout !== 1'b0) begin n_fail++; $display("FAIL nack_timeout: got %b expected 0", resp_timeout); end
    n_checks++; if (go_cnt - g0 != MR + 1) begin n_fail++; $display("FAIL nack_attempts: got %0d expected %0d", go_cnt - g0, MR + 1); end
    req = '0;
    step();
    nack_limit = 1;
    epoch++;
    g0 = go_cnt;
    req = 4'b0010;
    wait_resp(seen, 200);
    n_checks++; if (resp_valid !== 4'b0010) begin n_fail++; $display("FAIL nack_once_resp_valid: got %b expected 0010", resp_valid); end
    n_checks++; if (resp_success !== 1'b1) begin n_fail++; $display("FAIL nack_once_success: got %b expected 1", resp_success); end
    n_checks++; if (go_cnt - g0 != 2) begin n_fail++; $display("FAIL nack_once_attempts: got %0d expected 2", go_cnt - g0); end
    req = '0;
    step();
    nack_limit = 0;
    epoch++;
  endtask

  task automatic test_timeout();
    bit seen;
    int go_at, busy_grants, waited;
    hang = 1'b1;
    req = 4'b0100;
    step();
    go_at = last_go_cyc;
    n_checks++; if (m_go !== 1'b1) begin n_fail++; $display("FAIL tmo_go: got %b expected 1", m_go); end
    wait_resp(seen, 40);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tmo_resp_seen: got none expected a response"); end
    n_checks++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL tmo_resp_valid: got %b expected 0100", resp_valid); end
    n_checks++; if (resp_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", resp_timeout); end
    n_checks++; if (resp_success !== 1'b0) begin n_fail++; $display("FAIL tmo_success: got %b expected 0", resp_success); end
    n_checks++; if (resp_cyc - go_at != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles expected %0d", resp_cyc - go_at, TMO); end
    req = 4'b0001;
    busy_grants = 0;
    repeat (10) begin
      step();
      if (gnt != '0 || m_go) busy_grants++;
    end
    n_checks++; if (busy_grants != 0) begin n_fail++; $display("FAIL tmo_no_grant_busy: got %0d granted cycles expected 0", busy_grants); end
    hang = 1'b0;
    waited = 0;
    while (gnt == '0 && waited < 30) begin step(); waited++; end
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_regrant: got %b expected 0001", gnt); end
    wait_resp(seen, 50);
    n_checks++; if (resp_success !== 1'b1 || resp_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_recover: got success=%b timeout=%b expected 1/0", resp_success, resp_timeout); end
    req = '0;
    step();
  endtask

  task automatic test_stale_reset();
    bit seen;
    int early_resp, waited;
    start_dly = 4;
    hang = 1'b1;
    req = 4'b1000;
    step();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL stale_gnt: got %b expected 1000", gnt); end
    early_resp = 0;
    waited = 0;
    while (!m_busy && waited < 20) begin
      if (resp_valid != '0) early_resp++;
      step();
      waited++;
    end
    n_checks++; if (early_resp != 0) begin n_fail++; $display("FAIL stale_done_accepted: got %0d responses expected 0", early_resp); end
    n_checks++; if (m_go !== 1'b1 || gnt !== 4'b1000) begin n_fail++; $display("FAIL stale_still_issuing: got go=%b gnt=%b expected 1/1000", m_go, gnt); end
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || resp_valid !== 4'b0000) begin n_fail++; $display("FAIL midreset_gnt_resp: got gnt=%b resp=%b expected 0000/0000", gnt, resp_valid); end
    n_checks++; if (m_go !== 1'b0) begin n_fail++; $display("FAIL midreset_go: got %b expected 0", m_go); end
    n_checks++; if (m_addr !== 8'h00 || m_data !== 8'h00) begin n_fail++; $display("FAIL midreset_payload: got %h/%h expected 00/00", m_addr, m_data); end
    hang = 1'b0;
    start_dly = 0;
    req = '0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    req = 4'b1001;
    step();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL restart_gnt: got %b expected 0001", gnt); end
    wait_resp(seen, 50);
    n_checks++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL restart_resp: got %b expected 0001", resp_valid); end
    req = '0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_nack();
    test_timeout();
    test_stale_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
